// File: rtl/ycr_wb_pkg.sv
// Shared types and constants for the pipeline write-back arbiter.
// The write-request struct widths track the default XLEN/AWIDTH of the arbiter.
package ycr_wb_pkg;

    localparam int YCR_WB_XLEN      = 32;
    localparam int YCR_WB_AWIDTH    = 5;
    localparam int YCR_WB_OVF_LIMIT = 64;

    typedef struct packed {
        logic                     vd;
        logic [YCR_WB_AWIDTH-1:0] addr;
        logic [YCR_WB_XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/ycr_pipe_wb_lq.sv
// Synchronous FIFO with wrap-bit pointers; used to buffer LSU load returns.
// Only the pointers are reset; storage contents are don't-care while empty.
module ycr_pipe_wb_lq #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;

    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[PW-1:0]];
    assign wr_en = push & ~full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ycr_pipe_wb_arb.sv
// MPRF write-port arbiter: EXU results first, then queued load returns, then bypassed returns.
// Also keeps the pending-load scoreboard that drives EXU operand/destination hazards.
module ycr_pipe_wb_arb
    import ycr_wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int AWIDTH   = 5,
    parameter int LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_wb_req_i,
    input  logic [AWIDTH-1:0] exu_wb_addr_i,
    input  logic [XLEN-1:0]   exu_wb_data_i,
    input  logic              lsu_issue_i,
    input  logic [AWIDTH-1:0] lsu_issue_addr_i,
    input  logic              lsu_ret_vd_i,
    output logic              lsu_ret_rdy_o,
    input  logic [AWIDTH-1:0] lsu_ret_addr_i,
    input  logic [XLEN-1:0]   lsu_ret_data_i,
    input  logic [AWIDTH-1:0] exu_rs1_addr_i,
    input  logic [AWIDTH-1:0] exu_rs2_addr_i,
    output logic              rs1_hazard_o,
    output logic              rs2_hazard_o,
    output logic              rd_hazard_o,
    output logic              wb2mprf_w_req_o,
    output logic [AWIDTH-1:0] wb2mprf_rd_addr_o,
    output logic [XLEN-1:0]   wb2mprf_rd_data_o,
    output logic              lq_overflow_o
);

    localparam int LQW  = AWIDTH + XLEN;
    localparam int CNTW = $clog2(YCR_WB_OVF_LIMIT) + 1;

    logic                 lq_full, lq_empty, lq_push, lq_pop;
    logic [LQW-1:0]       lq_head;
    logic                 ret_acc, ret_byp, stall;
    wb_req_t              wb_sel;
    logic                 wb_sel_load;
    logic [2**AWIDTH-1:0] sb_q, sb_d;
    logic [CNTW-1:0]      stall_cnt_q, stall_cnt_d;
    logic                 ovf_q, ovf_d;

    // Ready depends only on registered queue occupancy, never on this cycle's pop.
    assign lsu_ret_rdy_o = ~lq_full & ~rst;
    assign ret_acc       = lsu_ret_vd_i & lsu_ret_rdy_o;

    ycr_pipe_wb_lq #(
        .WIDTH (LQW),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (lq_push),
        .push_data ({lsu_ret_addr_i, lsu_ret_data_i}),
        .pop       (lq_pop),
        .full      (lq_full),
        .empty     (lq_empty),
        .head      (lq_head)
    );

    always_comb begin
        wb_sel      = '0;
        wb_sel_load = 1'b0;
        lq_pop      = 1'b0;
        ret_byp     = 1'b0;
        if (exu_wb_req_i) begin
            wb_sel.vd   = 1'b1;
            wb_sel.addr = exu_wb_addr_i;
            wb_sel.data = exu_wb_data_i;
        end else if (!lq_empty) begin
            wb_sel.vd   = 1'b1;
            wb_sel.addr = lq_head[LQW-1:XLEN];
            wb_sel.data = lq_head[XLEN-1:0];
            wb_sel_load = 1'b1;
            lq_pop      = 1'b1;
        end else if (ret_acc) begin
            wb_sel.vd   = 1'b1;
            wb_sel.addr = lsu_ret_addr_i;
            wb_sel.data = lsu_ret_data_i;
            wb_sel_load = 1'b1;
            ret_byp     = 1'b1;
        end
        lq_push = ret_acc & ~ret_byp;
    end

    // x0 writes still arbitrate and consume, but never reach the register file.
    assign wb2mprf_w_req_o   = wb_sel.vd & (|wb_sel.addr) & ~rst;
    assign wb2mprf_rd_addr_o = wb_sel.addr;
    assign wb2mprf_rd_data_o = wb_sel.data;

    always_comb begin
        sb_d = sb_q;
        if (wb_sel.vd && wb_sel_load) begin
            sb_d[wb_sel.addr] = 1'b0;
        end
        if (lsu_issue_i) begin
            sb_d[lsu_issue_addr_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    assign rs1_hazard_o = sb_q[exu_rs1_addr_i];
    assign rs2_hazard_o = sb_q[exu_rs2_addr_i];
    assign rd_hazard_o  = sb_q[exu_wb_addr_i] & exu_wb_req_i;

    assign stall = lsu_ret_vd_i & ~lsu_ret_rdy_o;

    always_comb begin
        stall_cnt_d = '0;
        ovf_d       = ovf_q;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == CNTW'(YCR_WB_OVF_LIMIT)) ? stall_cnt_q
                                                                 : stall_cnt_q + CNTW'(1);
            if (stall_cnt_q == CNTW'(YCR_WB_OVF_LIMIT - 1)) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign lq_overflow_o = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef YCR_TRGT_SIMULATION
    // The EXU must stall on rd_hazard_o instead of overwriting a register awaiting its load.
    assert property (@(posedge clk) disable iff (rst) !(exu_wb_req_i && sb_q[exu_wb_addr_i]));
`endif

endmodule

// File: tb/tb_ycr_pipe_wb_arb.sv
// Self-checking bench for ycr_pipe_wb_arb: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of the write port and scoreboard.
module tb_ycr_pipe_wb_arb;

    logic        clk;
    logic        rst;
    logic        exu_req;
    logic [4:0]  exu_addr;
    logic [31:0] exu_data;
    logic        iss;
    logic [4:0]  iss_addr;
    logic        rvd;
    logic        rdy;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [4:0]  rs1, rs2;
    logic        rs1_hz, rs2_hz, rd_hz;
    logic        w_req;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    ycr_pipe_wb_arb #(.XLEN(32), .AWIDTH(5), .LQ_DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .exu_wb_req_i      (exu_req),
        .exu_wb_addr_i     (exu_addr),
        .exu_wb_data_i     (exu_data),
        .lsu_issue_i       (iss),
        .lsu_issue_addr_i  (iss_addr),
        .lsu_ret_vd_i      (rvd),
        .lsu_ret_rdy_o     (rdy),
        .lsu_ret_addr_i    (raddr),
        .lsu_ret_data_i    (rdata),
        .exu_rs1_addr_i    (rs1),
        .exu_rs2_addr_i    (rs2),
        .rs1_hazard_o      (rs1_hz),
        .rs2_hazard_o      (rs2_hz),
        .rd_hazard_o       (rd_hz),
        .wb2mprf_w_req_o   (w_req),
        .wb2mprf_rd_addr_o (w_addr),
        .wb2mprf_rd_data_o (w_data),
        .lq_overflow_o     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic clr_in();
        exu_req = 0; exu_addr = 0; exu_data = 0;
        iss = 0; iss_addr = 0;
        rvd = 0; raddr = 0; rdata = 0;
        rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_in();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic issue(input logic [4:0] a);
        @(negedge clk);
        clr_in();
        iss = 1; iss_addr = a;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr_in();
        rst = 1;
        @(negedge clk);
        #1;
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy_during got=%0b exp=0", rdy); end
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL reset_wreq_during got=%0b exp=0", w_req); end
        @(negedge clk);
        rst = 0;
        rs1 = 5'd5; rs2 = 5'd9;
        #1;
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy_after got=%0b exp=1", rdy); end
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL reset_wreq_after got=%0b exp=0", w_req); end
        checks++; if ({rs1_hz, rs2_hz, rd_hz} !== 3'b000) begin failures++; $display("FAIL reset_hazards got=%b exp=000", {rs1_hz, rs2_hz, rd_hz}); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    endtask

    task automatic test_exu_pass();
        @(negedge clk);
        clr_in();
        exu_req = 1; exu_addr = 5'd5; exu_data = 32'hDEADBEEF;
        #1;
        checks++; if (w_req !== 1'b1) begin failures++; $display("FAIL exu_wreq got=%0b exp=1", w_req); end
        checks++; if (w_addr !== 5'd5) begin failures++; $display("FAIL exu_addr got=%0d exp=5", w_addr); end
        checks++; if (w_data !== 32'hDEADBEEF) begin failures++; $display("FAIL exu_data got=%h exp=deadbeef", w_data); end
        checks++; if (rd_hz !== 1'b0) begin failures++; $display("FAIL exu_rd_hazard got=%0b exp=0", rd_hz); end
    endtask

    task automatic test_load_bypass();
        issue(5'd7);
        rs1 = 5'd7;
        #1;
        checks++; if (rs1_hz !== 1'b0) begin failures++; $display("FAIL byp_hz_same_cycle got=%0b exp=0", rs1_hz); end
        @(negedge clk);
        clr_in(); rs1 = 5'd7;
        #1;
        checks++; if (rs1_hz !== 1'b1) begin failures++; $display("FAIL byp_hz_pending got=%0b exp=1", rs1_hz); end
        @(negedge clk);
        rvd = 1; raddr = 5'd7; rdata = 32'h1234;
        #1;
        checks++; if ({w_req, w_addr} !== {1'b1, 5'd7}) begin failures++; $display("FAIL byp_write got=%0b/%0d exp=1/7", w_req, w_addr); end
        checks++; if (w_data !== 32'h1234) begin failures++; $display("FAIL byp_data got=%h exp=00001234", w_data); end
        @(negedge clk);
        rvd = 0;
        #1;
        checks++; if (rs1_hz !== 1'b0) begin failures++; $display("FAIL byp_hz_cleared got=%0b exp=0", rs1_hz); end
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL byp_no_repeat got=%0b exp=0", w_req); end
    endtask

    task automatic test_collision();
        issue(5'd9);
        @(negedge clk);
        clr_in();
        exu_req = 1; exu_addr = 5'd3; exu_data = 32'h33;
        rvd = 1; raddr = 5'd9; rdata = 32'hAA;
        #1;
        checks++; if ({w_req, w_addr, w_data} !== {1'b1, 5'd3, 32'h33}) begin failures++; $display("FAIL coll_exu got=%0b/%0d/%h exp=1/3/33", w_req, w_addr, w_data); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL coll_rdy0 got=%0b exp=1", rdy); end
        @(negedge clk);
        clr_in();
        #1;
        checks++; if ({w_req, w_addr, w_data} !== {1'b1, 5'd9, 32'hAA}) begin failures++; $display("FAIL coll_queued got=%0b/%0d/%h exp=1/9/aa", w_req, w_addr, w_data); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL coll_rdy1 got=%0b exp=1", rdy); end
        @(negedge clk);
        #1;
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL coll_drained got=%0b exp=0", w_req); end
    endtask

    task automatic test_queue_full();
        logic [31:0] d [3];
        logic [4:0]  exp_a [7];
        logic [31:0] exp_d [7];
        logic        exp_r [7];
        for (int i = 0; i < 3; i++) d[i] = $urandom;
        exp_a = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd10, 5'd11, 5'd12};
        exp_d = '{32'h100, 32'h101, 32'h102, 32'h103, d[0], d[1], d[2]};
        exp_r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        issue(5'd10); issue(5'd11); issue(5'd12);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            clr_in();
            if (c < 4) begin exu_req = 1; exu_addr = 5'(20 + c); exu_data = 32'h100 + c; end
            if (c < 6) begin rvd = 1; raddr = 5'(10 + (c < 2 ? c : 2)); rdata = d[c < 2 ? c : 2]; end
            #1;
            checks++; if (rdy !== exp_r[c]) begin failures++; $display("FAIL full_rdy c=%0d got=%0b exp=%0b", c, rdy, exp_r[c]); end
            checks++; if ({w_req, w_addr, w_data} !== {1'b1, exp_a[c], exp_d[c]}) begin failures++; $display("FAIL full_write c=%0d got=%0b/%0d/%h exp=1/%0d/%h", c, w_req, w_addr, w_data, exp_a[c], exp_d[c]); end
        end
        @(negedge clk);
        clr_in(); rs1 = 5'd10; rs2 = 5'd12;
        #1;
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL full_drained got=%0b exp=0", w_req); end
        checks++; if ({rs1_hz, rs2_hz} !== 2'b00) begin failures++; $display("FAIL full_sb_clear got=%b exp=00", {rs1_hz, rs2_hz}); end
    endtask

    task automatic test_issue_ret_same();
        issue(5'd4);
        @(negedge clk);
        clr_in();
        iss = 1; iss_addr = 5'd4;
        rvd = 1; raddr = 5'd4; rdata = 32'h44;
        #1;
        checks++; if ({w_req, w_addr, w_data} !== {1'b1, 5'd4, 32'h44}) begin failures++; $display("FAIL same_write got=%0b/%0d/%h exp=1/4/44", w_req, w_addr, w_data); end
        @(negedge clk);
        clr_in(); rs1 = 5'd4;
        exu_req = 1; exu_addr = 5'd4; exu_data = 32'h77;
        #1;
        checks++; if (rs1_hz !== 1'b1) begin failures++; $display("FAIL same_set_wins got=%0b exp=1", rs1_hz); end
        checks++; if (rd_hz !== 1'b1) begin failures++; $display("FAIL same_rd_hazard got=%0b exp=1", rd_hz); end
        checks++; if ({w_req, w_addr} !== {1'b1, 5'd4}) begin failures++; $display("FAIL same_exu_still_writes got=%0b/%0d exp=1/4", w_req, w_addr); end
        @(negedge clk);
        clr_in();
        rvd = 1; raddr = 5'd0; rdata = 32'h99;
        #1;
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL x0_ret_wreq got=%0b exp=0", w_req); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL x0_ret_rdy got=%0b exp=1", rdy); end
        @(negedge clk);
        clr_in();
        exu_req = 1; exu_addr = 5'd0; exu_data = 32'h1;
        #1;
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL x0_exu_wreq got=%0b exp=0", w_req); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL x0_queue_empty got=%0b exp=1", rdy); end
        @(negedge clk);
        clr_in();
        #1;
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL x0_nothing_queued got=%0b exp=0", w_req); end
        @(negedge clk);
        rvd = 1; raddr = 5'd4; rdata = 32'h55;
        #1;
        checks++; if ({w_req, w_addr, w_data} !== {1'b1, 5'd4, 32'h55}) begin failures++; $display("FAIL same_second_ret got=%0b/%0d/%h exp=1/4/55", w_req, w_addr, w_data); end
        @(negedge clk);
        clr_in(); rs1 = 5'd4;
        #1;
        checks++; if (rs1_hz !== 1'b0) begin failures++; $display("FAIL same_final_clear got=%0b exp=0", rs1_hz); end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 2 + 64; c++) begin
            @(negedge clk);
            clr_in();
            exu_req = 1; exu_addr = 5'd20; exu_data = 32'(c);
            rvd = 1; raddr = 5'(15 + (c < 2 ? c : 2)); rdata = 32'(c);
            #1;
            if (c == 2) begin
                checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL ovf_full got=%0b exp=0", rdy); end
            end
            if (c == 2 + 63) begin
                checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", ovf); end
            end
        end
        @(negedge clk);
        clr_in();
        #1;
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", ovf); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", ovf); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ovf_drained_rdy got=%0b exp=1", rdy); end
    endtask

    task automatic test_reset_mid();
        issue(5'd6);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clr_in();
            exu_req = 1; exu_addr = 5'(20 + c); exu_data = 32'(c);
            if (c < 2) begin rvd = 1; raddr = 5'(13 + c); rdata = 32'hC0 + c; end
        end
        rs1 = 5'd6;
        #1;
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL mid_full got=%0b exp=0", rdy); end
        checks++; if (rs1_hz !== 1'b1) begin failures++; $display("FAIL mid_pending got=%0b exp=1", rs1_hz); end
        @(negedge clk);
        clr_in();
        rst = 1;
        #1;
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL mid_wreq_in_reset got=%0b exp=0", w_req); end
        @(negedge clk);
        rst = 0;
        rs1 = 5'd6;
        #1;
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL mid_rdy_after got=%0b exp=1", rdy); end
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL mid_queue_empty got=%0b exp=0", w_req); end
        checks++; if ({rs1_hz, rs2_hz, rd_hz} !== 3'b000) begin failures++; $display("FAIL mid_hazards got=%b exp=000", {rs1_hz, rs2_hz, rd_hz}); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL mid_ovf_cleared got=%0b exp=0", ovf); end
        @(negedge clk);
        #1;
        checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL mid_still_empty got=%0b exp=0", w_req); end
    endtask

    task automatic test_random();
        bit          pend [32];
        logic [36:0] q [$];
        logic [4:0]  outst [$];
        int          idx;
        bit          listed;
        logic [4:0]  a;
        logic        e_wr, e_pop, e_byp, e_rdy, acc;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        do_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            clr_in();
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1 && !pend[a]) begin
                exu_req = 1; exu_addr = a; exu_data = $urandom;
            end
            a = 5'($urandom_range(0, 31));
            listed = 0;
            foreach (outst[k]) if (outst[k] == a && a != 0) listed = 1;
            if ($urandom_range(0, 9) < 4 && !pend[a] && !listed) begin
                iss = 1; iss_addr = a;
            end
            idx = 0;
            if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, outst.size() - 1);
                rvd = 1; raddr = outst[idx]; rdata = $urandom;
            end
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            #1;
            e_rdy = (q.size() < 2);
            acc   = rvd && e_rdy;
            e_wr = 0; e_pop = 0; e_byp = 0; e_addr = 0; e_data = 0;
            if (exu_req) begin
                e_wr = 1; e_addr = exu_addr; e_data = exu_data;
            end else if (q.size() > 0) begin
                e_wr = 1; e_pop = 1; {e_addr, e_data} = q[0];
            end else if (acc) begin
                e_wr = 1; e_byp = 1; e_addr = raddr; e_data = rdata;
            end
            checks++; if (rdy !== e_rdy) begin failures++; $display("FAIL rnd_rdy cyc=%0d got=%0b exp=%0b", cyc, rdy, e_rdy); end
            checks++; if (w_req !== (e_wr && e_addr != 0)) begin failures++; $display("FAIL rnd_wreq cyc=%0d got=%0b exp=%0b", cyc, w_req, e_wr && e_addr != 0); end
            if (e_wr && e_addr != 0) begin
                checks++; if ({w_addr, w_data} !== {e_addr, e_data}) begin failures++; $display("FAIL rnd_write cyc=%0d got=%0d/%h exp=%0d/%h", cyc, w_addr, w_data, e_addr, e_data); end
            end
            checks++; if ({rs1_hz, rs2_hz} !== {pend[rs1], pend[rs2]}) begin failures++; $display("FAIL rnd_rs_hazard cyc=%0d got=%b exp=%b", cyc, {rs1_hz, rs2_hz}, {pend[rs1], pend[rs2]}); end
            checks++; if (rd_hz !== (exu_req && pend[exu_addr])) begin failures++; $display("FAIL rnd_rd_hazard cyc=%0d got=%0b exp=%0b", cyc, rd_hz, exu_req && pend[exu_addr]); end
            if (e_pop) void'(q.pop_front());
            if (acc && !e_byp) q.push_back({raddr, rdata});
            if (acc) outst.delete(idx);
            if (e_wr && (e_pop || e_byp)) pend[e_addr] = 0;
            if (iss) begin pend[iss_addr] = 1; outst.push_back(iss_addr); end
            pend[0] = 0;
        end
    endtask

    initial begin
        rst = 1;
        clr_in();
        test_reset();
        test_exu_pass();
        test_load_bypass();
        test_collision();
        test_queue_full();
        test_issue_ret_same();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
